// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: h/v counters with registered syncs, active flag and strobes.
// Define VGA_TIMING_FRAME_COUNT_EN to add a 16-bit frame_count output.
module vga_timing_gen #(
    parameter int unsigned CNT_W    = 16,
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    parameter bit          HS_POL   = 1'b0,
    parameter bit          VS_POL   = 1'b0
) (
    input  logic             clk25MHz,
    input  logic             reset,
    input  logic             pix_en,
    output logic [CNT_W-1:0] h_count,
    output logic [CNT_W-1:0] v_count,
    output logic             hsync,
    output logic             vsync,
    output logic             active,
    output logic             line_start,
    output logic             frame_start
`ifdef VGA_TIMING_FRAME_COUNT_EN
    ,
    output logic [15:0]      frame_count
`endif
);

    localparam int unsigned H_TOTAL   = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL   = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned MAX_TOTAL = (H_TOTAL > V_TOTAL) ? H_TOTAL : V_TOTAL;

    if (((MAX_TOTAL - 1) >> CNT_W) != 0) begin : g_cnt_w_check
        $error("vga_timing_gen: CNT_W too small for H_TOTAL/V_TOTAL");
    end

    localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_ACT    = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_ACT    = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] HS_START = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [CNT_W-1:0] VS_START = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_ACTIVE + V_FP + V_SYNC - 1);

    logic [CNT_W-1:0] r_h_count, r_v_count;
    logic             r_hsync, r_vsync, r_active, r_line_start, r_frame_start;

    logic [CNT_W-1:0] w_h_nxt, w_v_nxt;
    logic             w_h_wrap, w_hs_on, w_vs_on, w_act, w_line_land, w_frame_land;

    // Outputs are decoded from the next position so every output describes the same pixel.
    always_comb begin
        w_h_wrap = (r_h_count == H_LAST);
        w_h_nxt  = w_h_wrap ? '0 : r_h_count + CNT_W'(1);
        w_v_nxt  = r_v_count;
        if (w_h_wrap) begin
            w_v_nxt = (r_v_count == V_LAST) ? '0 : r_v_count + CNT_W'(1);
        end
        w_hs_on      = (w_h_nxt >= HS_START) && (w_h_nxt <= HS_END);
        w_vs_on      = (w_v_nxt >= VS_START) && (w_v_nxt <= VS_END);
        w_act        = (w_h_nxt < H_ACT) && (w_v_nxt < V_ACT);
        w_line_land  = (w_h_nxt == '0);
        w_frame_land = w_line_land && (w_v_nxt == '0);
    end

    // Reset parks the raster on the last pixel so the first advance lands on (0,0).
    always_ff @(posedge clk25MHz) begin
        if (reset) begin
            r_h_count     <= H_LAST;
            r_v_count     <= V_LAST;
            r_hsync       <= ~HS_POL;
            r_vsync       <= ~VS_POL;
            r_active      <= 1'b0;
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
        end else if (pix_en) begin
            r_h_count     <= w_h_nxt;
            r_v_count     <= w_v_nxt;
            r_hsync       <= w_hs_on ? HS_POL : ~HS_POL;
            r_vsync       <= w_vs_on ? VS_POL : ~VS_POL;
            r_active      <= w_act;
            r_line_start  <= w_line_land;
            r_frame_start <= w_frame_land;
        end else begin
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
        end
    end

`ifdef VGA_TIMING_FRAME_COUNT_EN
    logic [15:0] r_frame_count;

    always_ff @(posedge clk25MHz) begin
        if (reset) begin
            r_frame_count <= 16'd0;
        end else if (pix_en && w_frame_land) begin
            r_frame_count <= r_frame_count + 16'd1;
        end
    end

    assign frame_count = r_frame_count;
`endif

    assign h_count     = r_h_count;
    assign v_count     = r_v_count;
    assign hsync       = r_hsync;
    assign vsync       = r_vsync;
    assign active      = r_active;
    assign line_start  = r_line_start;
    assign frame_start = r_frame_start;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: default 640x480 timing plus a tiny active-high-sync raster.
module tb_vga_timing_gen;

    logic clk = 1'b0;
    always #20 clk = ~clk;

    logic        rst0, en0, hs0, vs0, act0, ls0, fs0;
    logic [15:0] h0, v0;
    logic        rst1, en1, hs1, vs1, act1, ls1, fs1;
    logic [7:0]  h1, v1;
`ifdef VGA_TIMING_FRAME_COUNT_EN
    logic [15:0] fc0, fc1;
`endif

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    // Expected raster state, one set per instance
    int eh0, ev0, efc0;
    bit els0, efs0;
    int eh1, ev1, efc1;
    bit els1, efs1;

    vga_timing_gen u_dut0 (
        .clk25MHz    (clk),
        .reset       (rst0),
        .pix_en      (en0),
        .h_count     (h0),
        .v_count     (v0),
        .hsync       (hs0),
        .vsync       (vs0),
        .active      (act0),
        .line_start  (ls0),
        .frame_start (fs0)
`ifdef VGA_TIMING_FRAME_COUNT_EN
        ,
        .frame_count (fc0)
`endif
    );

    vga_timing_gen #(
        .CNT_W    (8),
        .H_ACTIVE (8),
        .H_FP     (2),
        .H_SYNC   (3),
        .H_BP     (3),
        .V_ACTIVE (4),
        .V_FP     (1),
        .V_SYNC   (1),
        .V_BP     (1),
        .HS_POL   (1'b1),
        .VS_POL   (1'b1)
    ) u_dut1 (
        .clk25MHz    (clk),
        .reset       (rst1),
        .pix_en      (en1),
        .h_count     (h1),
        .v_count     (v1),
        .hsync       (hs1),
        .vsync       (vs1),
        .active      (act1),
        .line_start  (ls1),
        .frame_start (fs1)
`ifdef VGA_TIMING_FRAME_COUNT_EN
        ,
        .frame_count (fc1)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick0(input bit r, input bit e);
        rst0 = r;
        en0  = e;
        @(posedge clk);
        #1;
        if (r) begin
            eh0 = 799; ev0 = 524; els0 = 0; efs0 = 0; efc0 = 0;
        end else if (e) begin
            if (eh0 == 799) begin
                eh0 = 0;
                ev0 = (ev0 == 524) ? 0 : ev0 + 1;
            end else begin
                eh0++;
            end
            els0 = (eh0 == 0);
            efs0 = els0 && (ev0 == 0);
            if (efs0) efc0 = (efc0 + 1) % 65536;
        end else begin
            els0 = 0; efs0 = 0;
        end
        check("d0_h", h0, eh0);
        check("d0_v", v0, ev0);
        check("d0_hsync", hs0, !(eh0 >= 656 && eh0 <= 751));
        check("d0_vsync", vs0, !(ev0 >= 490 && ev0 <= 491));
        check("d0_active", act0, (eh0 < 640 && ev0 < 480));
        check("d0_line_start", ls0, els0);
        check("d0_frame_start", fs0, efs0);
`ifdef VGA_TIMING_FRAME_COUNT_EN
        check("d0_frame_count", fc0, efc0);
`endif
    endtask

    task automatic tick1(input bit r, input bit e);
        rst1 = r;
        en1  = e;
        @(posedge clk);
        #1;
        if (r) begin
            eh1 = 15; ev1 = 6; els1 = 0; efs1 = 0; efc1 = 0;
        end else if (e) begin
            if (eh1 == 15) begin
                eh1 = 0;
                ev1 = (ev1 == 6) ? 0 : ev1 + 1;
            end else begin
                eh1++;
            end
            els1 = (eh1 == 0);
            efs1 = els1 && (ev1 == 0);
            if (efs1) efc1 = (efc1 + 1) % 65536;
        end else begin
            els1 = 0; efs1 = 0;
        end
        check("d1_h", h1, eh1);
        check("d1_v", v1, ev1);
        check("d1_hsync", hs1, (eh1 >= 10 && eh1 <= 12));
        check("d1_vsync", vs1, (ev1 == 5));
        check("d1_active", act1, (eh1 < 8 && ev1 < 4));
        check("d1_line_start", ls1, els1);
        check("d1_frame_start", fs1, efs1);
`ifdef VGA_TIMING_FRAME_COUNT_EN
        check("d1_frame_count", fc1, efc1);
`endif
    endtask

    initial begin
        #(40 * 50000);
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int hs_low, ls_cnt, fs_cnt, nfs, t2, t3, vs_hi, hs_hi, act_hi;
        rst0 = 1'b1; en0 = 1'b0; rst1 = 1'b1; en1 = 1'b0;

        // Reset state, and reset wins over pix_en
        tick0(1, 0);
        tick0(1, 1);
        check("rst_h", h0, 799);
        check("rst_v", v0, 524);
        check("rst_active", act0, 0);

        tick0(0, 1);
        check("first_h", h0, 0);
        check("first_v", v0, 0);
        check("first_frame_start", fs0, 1);
        check("first_line_start", ls0, 1);
        check("first_active", act0, 1);
        check("first_hsync", hs0, 1);
        check("first_vsync", vs0, 1);

        // Continuous sweep through two lines and into a third
        hs_low = 0;
        for (int i = 0; i < 1700; i++) begin
            tick0(0, 1);
            if (ev0 == 0 && hs0 == 1'b0) hs_low++;
        end
        check("hsync_low_width", hs_low, 96);
        check("sweep_h", h0, 100);
        check("sweep_v", v0, 2);

        // pix_en every 4th clk, crossing a line wrap
        while (eh0 != 790) tick0(0, 1);
        ls_cnt = 0;
        fs_cnt = 0;
        for (int k = 0; k < 20; k++) begin
            tick0(0, 1);
            ls_cnt += int'(ls0);
            for (int j = 0; j < 3; j++) begin
                tick0(0, 0);
                ls_cnt += int'(ls0);
                fs_cnt += int'(fs0);
            end
        end
        check("pulsed_line_start_clks", ls_cnt, 1);
        check("pulsed_hold_frame_start", fs_cnt, 0);
        check("pulsed_h", h0, 10);
        check("pulsed_v", v0, 3);

        // Mid-frame reset aborts immediately
        while (eh0 != 300) tick0(0, 1);
        tick0(1, 1);
        check("midrst_h", h0, 799);
        check("midrst_v", v0, 524);
        check("midrst_hsync", hs0, 1);
        tick0(0, 0);
        check("midrst_hold_h", h0, 799);
        tick0(0, 1);
        check("midrst_restart_h", h0, 0);
        check("midrst_restart_frame_start", fs0, 1);

        // Small raster with active-high syncs
        tick1(1, 0);
        check("d1_rst_hsync", hs1, 0);
        tick1(0, 1);
        check("d1_first_frame_start", fs1, 1);
        nfs = 1; t2 = 0; t3 = 0; vs_hi = 0; hs_hi = 0; act_hi = 0;
        for (int c = 1; c <= 400; c++) begin
            tick1(0, 1);
            vs_hi  += int'(vs1);
            hs_hi  += int'(hs1);
            act_hi += int'(act1);
            if (fs1) begin
                nfs++;
                if (nfs == 2) t2 = c;
                if (nfs == 3) begin
                    t3 = c;
`ifdef VGA_TIMING_FRAME_COUNT_EN
                    check("d1_frame_count_third", fc1, 3);
`endif
                end
            end
        end
        check("d1_second_frame_at", t2, 112);
        check("d1_frame_period", t3 - t2, 112);
        check("d1_frame_starts", nfs, 4);
        check("d1_vsync_high_clks", vs_hi, 48);
        check("d1_hsync_high_clks", hs_hi, 75);
        check("d1_active_clks", act_hi, 127);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Parametrised VGA raster timing generator. Single block that owns both the horizontal and vertical pixel counters.
- Produces hsync/vsync with configurable polarity, an active-video flag, and line/frame strobes.
- Sits between the pixel clock source and the pixel/framebuffer logic.
- Defaults give 640x480@60 on a 25 MHz pixel clock. A clock enable lets it run from a faster system clock.

Parameters:
- CNT_W, 16, width of the h_count/v_count outputs. Must hold max(H_TOTAL, V_TOTAL)-1; otherwise elaboration error.
- H_ACTIVE, 640, visible pixels per line.
- H_FP, 16, horizontal front porch, in pixels.
- H_SYNC, 96, horizontal sync width, in pixels.
- H_BP, 48, horizontal back porch, in pixels.
- V_ACTIVE, 480, visible lines per frame.
- V_FP, 10, vertical front porch, in lines.
- V_SYNC, 2, vertical sync width, in lines.
- V_BP, 33, vertical back porch, in lines.
- HS_POL, 0, hsync asserted level (0 = active-low).
- VS_POL, 0, vsync asserted level (0 = active-low).
- Derived values: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL likewise (525).

Ports:
- clk25MHz  in  1  pixel/system clock; all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- pix_en  in  1  advance enable; the raster moves one pixel per clk with pix_en=1. Tie to 1 for 25 MHz operation.
- h_count  out  CNT_W  current horizontal position, 0..H_TOTAL-1.
- v_count  out  CNT_W  current vertical position, 0..V_TOTAL-1.
- hsync  out  1  horizontal sync, polarity per HS_POL.
- vsync  out  1  vertical sync, polarity per VS_POL.
- active  out  1  high when h_count<H_ACTIVE and v_count<V_ACTIVE.
- line_start  out  1  one-clk strobe when the raster lands on h_count=0.
- frame_start  out  1  one-clk strobe when the raster lands on (0,0).

Behaviour:
- All outputs are registers. No combinational path from inputs to outputs.
- Reset (reset=1 at posedge) loads:
  - h_count=H_TOTAL-1, v_count=V_TOTAL-1.
  - hsync=~HS_POL, vsync=~VS_POL.
  - active=0, line_start=0, frame_start=0.
  - This is the decode-consistent last position of a frame, so the first pix_en after reset lands on (0,0) and fires frame_start.
- Reset has priority over pix_en. A mid-frame reset aborts the frame immediately, with no partial-line completion.
- Advance (reset=0, pix_en=1):
  - If h_count<H_TOTAL-1: h_count+1, v_count holds.
  - Else: h_count=0; v_count+1, or 0 when v_count=V_TOTAL-1.
- Hold (reset=0, pix_en=0): counters, hsync, vsync and active hold; line_start and frame_start go to 0.
- Decode latency is zero relative to the counters. On each advance, hsync/vsync/active/strobes load the decode of the NEW (h,v), so every output in a given cycle describes the same pixel.
- hsync asserted iff H_ACTIVE+H_FP <= h_count <= H_ACTIVE+H_FP+H_SYNC-1 (656..751 at defaults).
- vsync asserted iff V_ACTIVE+V_FP <= v_count <= V_ACTIVE+V_FP+V_SYNC-1 (490..491). vsync depends on v_count only and changes on the h wrap edge.
- line_start=1 for exactly one clk after an advance that lands on h_count=0. This includes the (0,0) landing, where it is coincident with frame_start.
- frame_start=1 for exactly one clk after an advance that lands on (0,0).
- With pix_en pulsed every Nth clk, strobes remain one clk wide, not N.
- Widths: counter compares are unsigned at CNT_W. Excess MSBs of h_count/v_count read 0.

Optional Feature:
- Macro VGA_TIMING_FRAME_COUNT_EN.
- Defined: adds output port frame_count, 16 bits.
  - Reset value 0.
  - Increments by 1 in the same clk that frame_start is set.
  - Wraps 65535 -> 0.
  - Unaffected by pix_en=0 hold cycles.
- Undefined: port and logic absent; all other behaviour identical.

Test Plan:
- Reset then pix_en=1 continuously, defaults -> first cycle after reset release: (h,v)=(0,0), frame_start=1, line_start=1, active=1, hsync=1, vsync=1. Next frame_start after exactly 800*525=420000 clks.
- Line sweep, defaults -> active falls when h_count goes 639->640; hsync=0 for h_count 656..751 (96 clks) and 1 at 752; h_count wraps 799->0 with v_count +1 and line_start=1 for one clk.
- Frame sweep, defaults -> vsync=0 exactly while v_count is 490..491, changing on the h wrap edge; v_count wraps 524->0 with frame_start=1. active=0 for all of v_count 480..524.
- pix_en=1 every 4th clk -> counters advance once per 4 clks; line_start/frame_start are 1 clk wide; levels hold between enables.
- Reset asserted at (h,v)=(300,200) -> next clk (799,524), syncs inactive, active=0. After release, next pix_en gives (0,0) with frame_start=1.
- HS_POL=1, VS_POL=1, H_ACTIVE=8, H_FP=2, H_SYNC=3, H_BP=3, V_ACTIVE=4, V_FP=1, V_SYNC=1, V_BP=1 -> hsync=1 only at h_count 10..12, vsync=1 only at v_count 5, frame period 16*7=112 clks. With VGA_TIMING_FRAME_COUNT_EN defined, frame_count reads 3 after the third frame_start.
